merge2_rr: RTL and testbench

//  2-to-1 stream merger with round-robin arbitration; the converging counterpart of the 1-to-2 demux.

---
 rtl/merge2_pkg.sv | 19 +
 rtl/merge2_rr_arb.sv | 34 +++
 rtl/merge2_rr.sv | 125 ++++++++++++
 tb/tb_merge2_rr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/merge2_pkg.sv
// Shared definitions for the 2-to-1 stream merger and other valid/ready stream blocks.
package merge2_pkg;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    localparam int WIDTH_DEF = 16;

    // Beat handshake field widths shared by the stream blocks
    localparam int VALID_W = 1;
    localparam int READY_W = 1;
    localparam int LAST_W  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } merge_state_t;

endpackage

// File: rtl/merge2_rr_arb.sv
// Combinational 2-way round-robin grant.
// When lock is set only lock_src may be granted; otherwise a lone requester
// wins and a tie goes to the source named by prio.
module rr_arb2
    import merge2_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       lock,
    input  logic       lock_src,
    output logic       gnt_valid,
    output logic       gnt_src
);

    // Grant selection
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_0;
        if (lock) begin
            gnt_valid = req[lock_src];
            gnt_src   = lock_src;
        end else if (req[0] && req[1]) begin
            gnt_valid = 1'b1;
            gnt_src   = prio;
        end else if (req[1]) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_1;
        end else if (req[0]) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_0;
        end
    end

endmodule

// File: rtl/merge2_rr.sv
// 2-to-1 valid/ready stream merger with round-robin arbitration and a
// registered output beat tagged with its source index.
// Optional feature: define MERGE2_BURST_LOCK_EN to keep the grant on one
// source until it delivers a beat with last=1.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | output register empty (out_valid=0)
// ST_HOLD | output register holds a beat (out_valid=1)
module merge2_rr
    import merge2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_last,
    input  logic             out_ready
);

    merge_state_t state, state_nxt;
    logic         prio;
    logic         accept;
    logic         gnt_valid;
    logic         gnt_src;
    logic         hs0, hs1, hs;
    logic         hs_src;
    logic         hs_last;
    logic         lock_q;
    logic         lock_src_q;

    assign out_valid = (state == ST_HOLD);
    assign accept    = !out_valid || out_ready;

    rr_arb2 u_arb (
        .req       ({in1_valid, in0_valid}),
        .prio      (prio),
        .lock      (lock_q),
        .lock_src  (lock_src_q),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // Readies are forced low during reset so nothing is consumed while held
    assign in0_ready = rst_n && accept && gnt_valid && (gnt_src == SRC_0);
    assign in1_ready = rst_n && accept && gnt_valid && (gnt_src == SRC_1);

    assign hs0     = in0_valid && in0_ready;
    assign hs1     = in1_valid && in1_ready;
    assign hs      = hs0 || hs1;
    assign hs_src  = hs1 ? SRC_1 : SRC_0;
    assign hs_last = hs1 ? in1_last : in0_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a handshake always fills the register; otherwise a taken beat empties it
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hs) begin
                    state_nxt = ST_HOLD;
                end else if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output beat register and round-robin pointer; winner drops to lowest priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= SRC_0;
            out_last <= 1'b0;
            prio     <= SRC_0;
        end else if (hs) begin
            out_data <= hs1 ? in1_data : in0_data;
            out_src  <= hs_src;
            out_last <= hs_last;
            prio     <= ~hs_src;
        end
    end

`ifdef MERGE2_BURST_LOCK_EN
    // Burst lock: a beat without last pins the grant to its source until last arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_0;
        end else if (hs) begin
            lock_q     <= !hs_last;
            lock_src_q <= hs_src;
        end
    end
`else
    assign lock_q     = 1'b0;
    assign lock_src_q = SRC_0;
`endif

endmodule

// File: tb/tb_merge2_rr.sv
// Directed self-checking bench for merge2_rr.
// Producers advance their data counters when their beat is accepted; an
// independent expected-order model checks every output beat.
module tb_merge2_rr;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid, in0_last, in0_ready;
    logic         in1_valid, in1_last, in1_ready;
    logic [W-1:0] in0_data, in1_data;
    logic         out_valid, out_src, out_last, out_ready;
    logic [W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    int c0 = 0, c1 = 0;      // producer beat counters
    int e0 = 0, e1 = 0;      // expected-beat counters (model)
    int burst_base = 0;
    bit burst_on = 0;

    merge2_rr #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        in0_data = 16'hA000 + W'(c0);
        in1_data = 16'hB000 + W'(c1);
        in0_last = burst_on ? ((c0 - burst_base) == 3) : 1'b1;
        in1_last = 1'b1;
    endtask

    // One clock: producers react to the handshake they saw before the edge
    task automatic step();
        logic h0, h1;
        h0 = in0_valid && in0_ready;
        h1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (h0) c0++;
        if (h1) c1++;
        drive_data();
        #1;
    endtask

    // Check the registered beat against the model, then advance the model
    task automatic expect_beat(input string tag, input logic src);
        logic [W-1:0] d;
        logic         l;
        if (src) begin
            d = 16'hB000 + W'(e1);
            l = 1'b1;
            e1++;
        end else begin
            d = 16'hA000 + W'(e0);
            l = burst_on ? ((e0 - burst_base) == 3) : 1'b1;
            e0++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_src"},   32'(out_src),   32'(src));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    logic exp_src;
    logic [4:0] burst_exp;

    initial begin
        rst_n     = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        drive_data();

        // Reset
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_rdy0",      32'(in0_ready), 32'd0);
        check("rst_rdy1",      32'(in1_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_rdy0", 32'(in0_ready), 32'd1);
        check("rel_rdy1", 32'(in1_ready), 32'd0);
        step();
        expect_beat("first", 1'b0);

        // Alternation over 100 beats
        exp_src = 1'b1;
        for (int k = 0; k < 100; k++) begin
            check("alt_onehot", 32'(in0_ready && in1_ready), 32'd0);
            step();
            expect_beat("alt", exp_src);
            exp_src = ~exp_src;
        end

        // Backpressure: held beat is source 0, so source 1 goes next
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_rdy0", 32'(in0_ready), 32'd0);
            check("bp_rdy1", 32'(in1_ready), 32'd0);
            step();
            check("bp_src",  32'(out_src),  32'd0);
            check("bp_data", 32'(out_data), 32'(16'hA000 + W'(e0 - 1)));
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy0", 32'(in0_ready), 32'd0);
        check("bp_rel_rdy1", 32'(in1_ready), 32'd1);
        step();
        expect_beat("bp_next", 1'b1);

        // Single source at full rate
        in0_valid = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("single_rdy1", 32'(in1_ready), 32'd1);
            step();
            expect_beat("single", 1'b1);
        end
        in0_valid = 1'b1;
        #1;
        check("tie_rdy0", 32'(in0_ready), 32'd1);
        check("tie_rdy1", 32'(in1_ready), 32'd0);
        step();
        expect_beat("tie", 1'b0);

        // Async reset mid-stream: held beat is dropped, prio returns to 0
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        check("arst_rdy0",  32'(in0_ready), 32'd0);
        check("arst_rdy1",  32'(in1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_rel_rdy0", 32'(in0_ready), 32'd1);
        check("arst_rel_rdy1", 32'(in1_ready), 32'd0);

        // Source 0 presents a 4-beat burst while source 1 stays valid
        burst_on   = 1'b1;
        burst_base = c0;
        e0         = c0;
        e1         = c1;
        drive_data();
        #1;
`ifdef MERGE2_BURST_LOCK_EN
        burst_exp = 5'b10000;
`else
        burst_exp = 5'b01010;
`endif
        for (int k = 0; k < 5; k++) begin
            step();
            expect_beat("burst", burst_exp[k]);
        end

        // Drain
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
